// File: rtl/vga_sync_if.sv
// Scan-timing bundle between the VGA sync controller and the pixel generator.
// The controller drives the timing outputs; the consumer drives enable.
interface vga_sync_if #(
  parameter int CNT_W = 10
);
  logic             enable;
  logic             pixel_tick;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic             frame_start;

  modport master (
    input  enable,
    output pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_start
  );

  modport slave (
    output enable,
    input  pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_start
  );
endinterface

// File: rtl/vga_sync_controller.sv
// Single-clock VGA scan generator: pixel divider, h/v counters and sync decode.
// Define VGA_SYNC_REG_OUT_EN to register hsync/vsync/video_on (one pixel lag).
module vga_sync_controller #(
  parameter int PIXEL_DIV = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CNT_W     = 10
) (
  input logic        clock,
  input logic        reset,
  vga_sync_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             tick;
  logic             hsync_dec;
  logic             vsync_dec;
  logic             video_dec;

  // Gating with reset keeps the tick quiet during reset even when PIXEL_DIV is 1.
  assign tick = reset && vga.enable && (div == DIV_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div     <= '0;
      h_count <= '0;
      v_count <= '0;
    end else if (vga.enable) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      if (tick) begin
        if (h_count == H_LAST) begin
          h_count <= '0;
          v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end else begin
          h_count <= h_count + 1'b1;
        end
      end
    end
  end

  always_comb begin
    hsync_dec = !((h_count >= HS_START) && (h_count < HS_END));
    vsync_dec = !((v_count >= VS_START) && (v_count < VS_END));
    video_dec = (h_count < H_VIS) && (v_count < V_VIS);
  end

`ifdef VGA_SYNC_REG_OUT_EN
  logic hsync_q;
  logic vsync_q;
  logic video_q;

  // Sampled from the pre-increment counters, so these trail pixel_x/pixel_y by one pixel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b0;
    end else if (tick) begin
      hsync_q <= hsync_dec;
      vsync_q <= vsync_dec;
      video_q <= video_dec;
    end
  end

  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.video_on = video_q;
`else
  assign vga.hsync    = hsync_dec;
  assign vga.vsync    = vsync_dec;
  assign vga.video_on = video_dec;
`endif

  assign vga.pixel_tick  = tick;
  assign vga.pixel_x     = h_count;
  assign vga.pixel_y     = v_count;
  assign vga.frame_start = tick && (h_count == '0) && (v_count == '0);
endmodule
